// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetcher with an in-order response FIFO.
// Fetch requests are credit-limited so that buffered plus in-flight words never exceed DEPTH.
// A redirect flushes the FIFO, retargets fetch, and drops the responses still in flight.
// Optional feature macro: IPQ_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IPQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t           fifo_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;

    logic             credit_ok;
    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_push;
    logic             pop;

    // Handshake decode; a response with nothing outstanding is a stray and is ignored
    assign credit_ok     = (SUM_W'(occupancy) + SUM_W'(outstanding)) < SUM_W'(DEPTH);
    assign mem_req_valid = RST & ~redirect & credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid & mem_req_ready;
    assign rsp_fire      = mem_rsp_valid & (outstanding != '0);
    assign rsp_push      = rsp_fire & (discard == '0) & ~redirect;
    assign pop           = inst_valid & inst_ready & ~redirect;

    assign inst_valid    = (occupancy != '0);
    assign inst          = fifo_mem[head].word;
    assign inst_pc       = fifo_mem[head].pc;

    // Queue, pointer and credit state; redirect outranks fetch, response and pop
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            head        <= '0;
            tail        <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
        end else if (redirect) begin
            // Every response still owed, minus one landing now, belongs to the old path
            occupancy   <= '0;
            tail        <= head;
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= outstanding - CNT_W'(rsp_fire);
            discard     <= outstanding - CNT_W'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            if (rsp_fire && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
            if (rsp_push) begin
                fifo_mem[tail] <= '{pc: rsp_pc, word: mem_rsp_data};
                tail           <= tail + PTR_W'(1);
                rsp_pc         <= rsp_pc + 32'd4;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            occupancy <= occupancy + CNT_W'(rsp_push) - CNT_W'(pop);
        end
    end

`ifdef IPQ_PERF_CNT_EN
    // Accepted-request and redirect-cycle counters, free-running with natural wrap
    always_ff @(posedge CLK) begin
        if (!RST) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(req_fire);
            perf_flush_cnt <= perf_flush_cnt + 32'(redirect);
        end
    end
`endif

    // Credit invariants that make overflow and discard underflow impossible
    always @(posedge CLK) begin
        if (RST) begin
            assert (occupancy <= CNT_W'(DEPTH))
                else $error("occupancy exceeds DEPTH");
            assert (discard <= outstanding)
                else $error("discard exceeds outstanding");
        end
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle core's instruction decode. It issues sequential word fetches to instruction memory through a valid/ready request channel, buffers in-order responses in a small FIFO, and presents one instruction plus its PC per cycle to the core. On a taken branch or jump, the core's redirect flushes the queue and discards stale in-flight responses.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- CLK  in  1  single clock; all state updates on posedge
- RST  in  1  synchronous, active-low reset; sampled on posedge CLK
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  fetch byte address, word aligned
- mem_req_ready  in  1  memory accepts request this cycle
- mem_rsp_valid  in  1  response word valid; in request order, at least 1 cycle after acceptance
- mem_rsp_data  in  32  instruction word
- redirect  in  1  core requests flush and refetch
- redirect_pc  in  32  new fetch address, word aligned
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction
- inst_pc  out  32  PC of head instruction
- inst_ready  in  1  core consumes head this cycle

## Operation
- State: fetch_pc, rsp_pc, a FIDO of DEPTH × {pc, inst}, occupancy count, outstanding count (both clog2(DEPTH)+1 bits), and discard count.
- Request: mem_req_valid = RST & !redirect & (occupancy + outstanding < DEPTH); mem_req_addr = fetch_pc. On accept (valid & ready), fetch_pc += 4 (mod 2^32 wrap) and outstanding += 1.
- Response: mem_rsp_valid decrements outstanding. If discard > 0, the word is dropped and discard -= 1. Otherwise {rsp_pc, mem_rsp_data} is pushed and rsp_pc += 4. If mem_rsp_valid arrives with outstanding == 0, it is ignored and no state changes.
- Pop: inst_valid = (occupancy != 0); inst/inst_pc come from the head register. inst_valid & inst_ready pops. Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (priority over everything): FIFO is cleared (occupancy 0); fetch_pc and rsp_pc are set to redirect_pc; discard is set to outstanding − mem_rsp_valid. The response arriving in the redirect cycle is dropped. No request is issued in the redirect cycle. A pop in the redirect cycle is a no-op.
- Consecutive redirects: the last one wins. Discard is recomputed from total outstanding each time.
- Overflow is impossible by credit rule. Simulation asserts occupancy ≤ DEPTH and discard ≤ outstanding.

## Timing
- Reset values: fetch_pc = rsp_pc = RESET_PC; occupancy, outstanding and discard = 0; inst_valid = 0; inst = 0; inst_pc = 0; mem_req_valid = 0 while RST = 0.
- The first request is visible in the cycle after RST deasserts.
- Response-to-output latency is 1 cycle: a response captured at edge N gives inst_valid = 1 after edge N (visible in cycle N+1) when the queue was empty.
- Redirect at edge N: inst_valid = 0 and a request to redirect_pc in cycle N+1 (subject to credit). The first redirect-path instruction appears 1 cycle after its response.
- Steady-state throughput is 1 instruction per cycle with a 1-cycle memory.
- Reset asserted mid-operation overrides redirect and discards all in-flight state. Late responses after reset are ignored via outstanding == 0.

## Configuration
- IPQ_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_cnt [31:0] (accepted requests) and perf_flush_cnt [31:0] (redirect cycles).
  - Both counters reset to 0, wrap at 2^32, and count regardless of discard.
- IPQ_PERF_CNT_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC = 0, memory always ready, 1-cycle latency, inst_ready = 1 → requests 0, 4, 8, …; inst_pc 0, 4, 8 on consecutive cycles after a 2-cycle startup; inst matches memory.
- inst_ready = 0 held → exactly DEPTH = 4 requests accepted, then mem_req_valid = 0; after 4 pops, fetch resumes at 0x10.
- Memory latency 3 with 3 requests outstanding, redirect to 0x100 → those 3 responses are dropped; the next inst_pc is 0x100, then 0x104.
- Redirect in the same cycle as mem_rsp_valid and a pop → response dropped, discard = outstanding − 1, inst_valid = 0 next cycle.
- RST low for one cycle mid-stream with outstanding = 2, then stray responses → ignored; fetch restarts at RESET_PC with inst_valid = 0 until the first new response.
- IPQ_PERF_CNT_EN defined: 10 accepted requests and 2 redirects → perf_fetch_cnt = 10, perf_flush_cnt = 2; both read 0 after reset.
